// File: rtl/stack_ctrl_pkg.sv
// Shared fault encodings and controller state type for the stack pointer block.
package stack_ctrl_pkg;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;
    localparam logic [1:0] FC_LOAD = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

endpackage

// File: rtl/stack_addr_drv.sv
// Frame-offset adder and tri-state driver for the shared address bus.
module stack_addr_drv #(
    parameter int AW        = 8,
    parameter int OW        = 4,
    parameter bit GROW_DOWN = 1'b0
) (
    input  logic [AW-1:0] sp_i,
    input  logic          spa_i,
    input  logic          ofse_i,
    input  logic [OW-1:0] ofs_i,
    inout  wire  [AW-1:0] addr_io
);

    logic [AW-1:0] ofs_ext;
    logic [AW-1:0] eff;

    assign ofs_ext = AW'(ofs_i);

    // Frame slots lie back toward the base, i.e. opposite the push direction.
    always_comb begin
        eff = sp_i;
        if (ofse_i) eff = GROW_DOWN ? (sp_i + ofs_ext) : (sp_i - ofs_ext);
    end

    assign addr_io = spa_i ? eff : {AW{1'bz}};

endmodule

// File: rtl/stack_ctrl.sv
// Stack pointer controller: push/pop/load with bounds faults, latched until cleared.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int AW        = 8,
    parameter int BASE      = 0,
    parameter int LIMIT     = 2**AW-1,
    parameter bit GROW_DOWN = 1'b0,
    parameter int OW        = 4
) (
    input  logic          CLK,
    input  logic          AR,
    input  logic          SPI,
    input  logic          SPD,
    input  logic          SPL,
    input  logic [AW-1:0] DIN,
    input  logic          SPA,
    input  logic          OFSE,
    input  logic [OW-1:0] OFS,
    input  logic          FCLR,
    inout  wire  [AW-1:0] ADDR,
    output logic [AW-1:0] COUNT,
    output logic          EMPTY,
    output logic          FULL,
    output logic [1:0]    FCODE
);

    localparam logic [AW-1:0] BASE_V  = AW'(BASE);
    localparam logic [AW-1:0] LIMIT_V = AW'(LIMIT);

    if ((!GROW_DOWN && !(BASE < LIMIT)) || (GROW_DOWN && !(BASE > LIMIT))) begin : g_bad_order
        $error("stack_ctrl: BASE/LIMIT ordering does not match GROW_DOWN");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] sp_q, sp_d;
    logic [1:0]    fcode_q, fcode_d;
    logic          din_ok;
    logic [AW-1:0] sp_push, sp_pop;

    assign din_ok  = GROW_DOWN ? (DIN <= BASE_V && DIN >= LIMIT_V)
                               : (DIN >= BASE_V && DIN <= LIMIT_V);
    assign sp_push = GROW_DOWN ? sp_q - 1'b1 : sp_q + 1'b1;
    assign sp_pop  = GROW_DOWN ? sp_q + 1'b1 : sp_q - 1'b1;

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        fcode_d = fcode_q;
        unique case (state_q)
            ST_RUN: begin
                if (SPL) begin
                    if (din_ok) sp_d = DIN;
                    else begin
                        fcode_d = FC_LOAD;
                        state_d = ST_FAULT;
                    end
                end else if (SPI && SPD) begin
                    sp_d = sp_q;
                end else if (SPI) begin
                    if (sp_q == LIMIT_V) begin
                        fcode_d = FC_OVF;
                        state_d = ST_FAULT;
                    end else sp_d = sp_push;
                end else if (SPD) begin
                    if (sp_q == BASE_V) begin
                        fcode_d = FC_UNF;
                        state_d = ST_FAULT;
                    end else sp_d = sp_pop;
                end
            end
            ST_FAULT: begin
                // Requests presented alongside the clear are dropped, not queued.
                if (FCLR) begin
                    fcode_d = FC_NONE;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (AR) begin
            state_q <= ST_RUN;
            sp_q    <= BASE_V;
            fcode_q <= FC_NONE;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fcode_q <= fcode_d;
        end
    end

    assign COUNT = GROW_DOWN ? (BASE_V - sp_q) : (sp_q - BASE_V);
    assign EMPTY = (sp_q == BASE_V);
    assign FULL  = (sp_q == LIMIT_V);
    assign FCODE = fcode_q;

    stack_addr_drv #(
        .AW        (AW),
        .OW        (OW),
        .GROW_DOWN (GROW_DOWN)
    ) u_addr_drv (
        .sp_i    (sp_q),
        .spa_i   (SPA),
        .ofse_i  (OFSE),
        .ofs_i   (OFS),
        .addr_io (ADDR)
    );

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboarded bench: three stack_ctrl configurations share one random stimulus stream.
module tb_stack_ctrl;

    localparam int N = 3;

    typedef struct packed {
        bit         ar, spi, spd, spl;
        logic [7:0] din;
        bit         spa, ofse;
        logic [3:0] ofs;
        bit         fclr, xen;
        logic [7:0] xv;
    } stim_t;

    typedef struct packed {
        logic [N-1:0][7:0] cnt;
        logic [N-1:0]      emp, ful;
        logic [N-1:0][1:0] fc;
        logic              achk;
        logic [N-1:0][7:0] addr;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       AR = 1'b1, SPI = 1'b0, SPD = 1'b0, SPL = 1'b0;
    logic       SPA = 1'b0, OFSE = 1'b0, FCLR = 1'b0, ext_en = 1'b0;
    logic [7:0] DIN = '0, ext_val = '0;
    logic [3:0] OFS = '0;

    wire [7:0] addr0, addr1, addr2;
    assign addr0 = ext_en ? ext_val : 8'bz;
    assign addr1 = ext_en ? ext_val : 8'bz;
    assign addr2 = ext_en ? ext_val : 8'bz;

    logic [N-1:0][7:0] cnt_w, addr_w;
    logic [N-1:0]      emp_w, ful_w;
    logic [N-1:0][1:0] fc_w;
    assign addr_w = {addr2, addr1, addr0};

    stack_ctrl u_def (
        .CLK(CLK), .AR(AR), .SPI(SPI), .SPD(SPD), .SPL(SPL), .DIN(DIN), .SPA(SPA),
        .OFSE(OFSE), .OFS(OFS), .FCLR(FCLR), .ADDR(addr0), .COUNT(cnt_w[0]),
        .EMPTY(emp_w[0]), .FULL(ful_w[0]), .FCODE(fc_w[0]));

    stack_ctrl #(.LIMIT(3)) u_lim (
        .CLK(CLK), .AR(AR), .SPI(SPI), .SPD(SPD), .SPL(SPL), .DIN(DIN), .SPA(SPA),
        .OFSE(OFSE), .OFS(OFS), .FCLR(FCLR), .ADDR(addr1), .COUNT(cnt_w[1]),
        .EMPTY(emp_w[1]), .FULL(ful_w[1]), .FCODE(fc_w[1]));

    stack_ctrl #(.GROW_DOWN(1'b1), .BASE(255), .LIMIT(240)) u_dn (
        .CLK(CLK), .AR(AR), .SPI(SPI), .SPD(SPD), .SPL(SPL), .DIN(DIN), .SPA(SPA),
        .OFSE(OFSE), .OFS(OFS), .FCLR(FCLR), .ADDR(addr2), .COUNT(cnt_w[2]),
        .EMPTY(emp_w[2]), .FULL(ful_w[2]), .FCODE(fc_w[2]));

    // Reference model: the pointer as a plain integer, fault as a nonzero code.
    int p_base[N] = '{0, 0, 255};
    int p_lim[N]  = '{255, 3, 240};
    int p_dir[N]  = '{1, 1, -1};
    int msp[N];
    int mfc[N];

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit in_rng(input int i, input int v);
        int lo = (p_base[i] < p_lim[i]) ? p_base[i] : p_lim[i];
        int hi = (p_base[i] < p_lim[i]) ? p_lim[i] : p_base[i];
        return (v >= lo) && (v <= hi);
    endfunction

    task automatic model(input stim_t s);
        exp_t e;
        e = '0;
        e.achk = s.spa || s.xen;
        for (int i = 0; i < N; i++) begin
            if (s.ar) begin
                msp[i] = p_base[i];
                mfc[i] = 0;
            end else if (mfc[i] != 0) begin
                if (s.fclr) mfc[i] = 0;
            end else if (s.spl) begin
                if (in_rng(i, int'(s.din))) msp[i] = int'(s.din);
                else mfc[i] = 3;
            end else if (s.spi && s.spd) begin
                msp[i] = msp[i];
            end else if (s.spi) begin
                if (msp[i] == p_lim[i]) mfc[i] = 1;
                else msp[i] += p_dir[i];
            end else if (s.spd) begin
                if (msp[i] == p_base[i]) mfc[i] = 2;
                else msp[i] -= p_dir[i];
            end
            e.cnt[i] = 8'((msp[i] > p_base[i]) ? msp[i] - p_base[i] : p_base[i] - msp[i]);
            e.emp[i] = (msp[i] == p_base[i]);
            e.ful[i] = (msp[i] == p_lim[i]);
            e.fc[i]  = 2'(mfc[i]);
            if (s.spa) e.addr[i] = 8'((s.ofse ? msp[i] - p_dir[i] * int'(s.ofs) : msp[i]) & 255);
            else       e.addr[i] = s.xv;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input stim_t s);
        AR = s.ar; SPI = s.spi; SPD = s.spd; SPL = s.spl; DIN = s.din;
        SPA = s.spa; OFSE = s.ofse; OFS = s.ofs; FCLR = s.fclr;
        ext_en = s.xen && !s.spa; ext_val = s.xv;
        @(posedge CLK);
        model(s);
        @(negedge CLK);
        #1;
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("sb_count[%0d]", i), int'(cnt_w[i]), int'(e.cnt[i]));
                    chk($sformatf("sb_empty[%0d]", i), int'(emp_w[i]), int'(e.emp[i]));
                    chk($sformatf("sb_full[%0d]", i),  int'(ful_w[i]), int'(e.ful[i]));
                    chk($sformatf("sb_fcode[%0d]", i), int'(fc_w[i]),  int'(e.fc[i]));
                    if (e.achk)
                        chk($sformatf("sb_addr[%0d]", i), int'(addr_w[i]), int'(e.addr[i]));
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cyc;
        for (int i = 0; i < N; i++) begin msp[i] = p_base[i]; mfc[i] = 0; end

        s = '0; s.ar = 1'b1;
        step(s); step(s);
        for (int i = 0; i < N; i++) begin
            chk("rst_count", int'(cnt_w[i]), 0);
            chk("rst_empty", int'(emp_w[i]), 1);
            chk("rst_full",  int'(ful_w[i]), 0);
            chk("rst_fcode", int'(fc_w[i]),  0);
        end

        // Three pushes, then pointer and frame addressing.
        s = '0; s.spi = 1'b1;
        repeat (3) step(s);
        s = '0; s.spa = 1'b1;
        step(s);
        chk("push3_count", int'(cnt_w[0]), 3);
        chk("push3_addr",  int'(addr_w[0]), 8'h03);
        chk("lim_full",    int'(ful_w[1]), 1);
        s.ofse = 1'b1; s.ofs = 4'd2;
        step(s);
        chk("frame_addr_up", int'(addr_w[0]), 8'h01);
        chk("frame_addr_dn", int'(addr_w[2]), 8'hFE);

        // Overflow on the LIMIT=3 instance, ignored pop, clear, then pop.
        s = '0; s.spi = 1'b1; step(s);
        chk("ovf_fcode", int'(fc_w[1]), 1);
        chk("ovf_count", int'(cnt_w[1]), 3);
        s = '0; s.spd = 1'b1; step(s);
        chk("fault_ignores_pop", int'(cnt_w[1]), 3);
        s = '0; s.fclr = 1'b1; s.spi = 1'b1; step(s);
        chk("fclr_fcode", int'(fc_w[1]), 0);
        chk("fclr_drops_req", int'(cnt_w[1]), 3);
        s = '0; s.spd = 1'b1; step(s);
        chk("pop_after_clr", int'(cnt_w[1]), 2);

        // Underflow, then reset out of fault.
        s = '0; s.ar = 1'b1; step(s);
        s = '0; s.spd = 1'b1; step(s);
        chk("unf_fcode", int'(fc_w[0]), 2);
        chk("unf_empty", int'(emp_w[0]), 1);
        s = '0; s.ar = 1'b1; s.spi = 1'b1; step(s);
        chk("rst_in_fault", int'(fc_w[0]), 0);
        chk("rst_in_fault_cnt", int'(cnt_w[0]), 0);

        // Simultaneous push/pop is a no-op; load beats push.
        s = '0; s.spi = 1'b1; step(s); step(s);
        s.spd = 1'b1; step(s);
        chk("pushpop_count", int'(cnt_w[0]), 2);
        chk("pushpop_fcode", int'(fc_w[0]), 0);
        s = '0; s.spl = 1'b1; s.spi = 1'b1; s.din = 8'h10; step(s);
        chk("load_wins", int'(cnt_w[0]), 8'h10);
        chk("load_oor_lim", int'(fc_w[1]), 3);

        // Downward-growing instance.
        s = '0; s.ar = 1'b1; step(s);
        s = '0; s.spi = 1'b1; step(s); step(s);
        s = '0; s.spa = 1'b1; step(s);
        chk("dn_addr", int'(addr_w[2]), 8'hFD);
        chk("dn_count", int'(cnt_w[2]), 2);
        s = '0; s.spl = 1'b1; s.din = 8'h05; step(s);
        chk("dn_load_oor", int'(fc_w[2]), 3);

        // Bus released: an external driver must be seen unchanged.
        s = '0; s.ar = 1'b1; step(s);
        for (int k = 0; k < 12; k++) begin
            s = '0;
            s.spi = 1'b1;
            s.xen = 1'b1;
            s.xv  = 8'($urandom);
            step(s);
            chk("ext_drv", int'(addr_w[0]), int'(s.xv));
        end

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            s = '0;
            s.ar   = ($urandom_range(0, 99) < 2);
            s.spi  = ($urandom_range(0, 99) < 45);
            s.spd  = ($urandom_range(0, 99) < 35);
            s.spl  = ($urandom_range(0, 99) < 6);
            s.fclr = ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 2))
                0:       s.din = 8'($urandom);
                1:       s.din = 8'($urandom_range(0, 5));
                default: s.din = 8'($urandom_range(236, 255));
            endcase
            s.spa  = $urandom_range(0, 1);
            s.ofse = $urandom_range(0, 1);
            s.ofs  = 4'($urandom);
            s.xen  = !s.spa && ($urandom_range(0, 1) == 1);
            s.xv   = 8'($urandom);
            step(s);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge CLK);
            wait_cyc++;
        end
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, meaning address/pointer width in bits.
REQ-002 SHALL have parameter BASE, default 0, meaning pointer value of an empty stack.
REQ-003 SHALL have parameter LIMIT, default 2**AW-1, meaning pointer value of a full stack.
REQ-004 SHALL have parameter GROW_DOWN, default 0, meaning push decrements when 1 and increments when 0.
REQ-005 SHALL have parameter OW, default 4, meaning frame-offset width.
REQ-006 SHALL have port CLK  input  1  system clock, all state updates on rising edge.
REQ-007 SHALL have port AR  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port SPI  input  1  push request, one entry per asserted cycle.
REQ-009 SHALL have port SPD  input  1  pop request, one entry per asserted cycle.
REQ-010 SHALL have port SPL  input  1  load pointer from DIN.
REQ-011 SHALL have port DIN  input  AW  load value.
REQ-012 SHALL have port SPA  input  1  drive ADDR with the pointer.
REQ-013 SHALL have port OFSE  input  1  when SPA is high, drive the pointer minus OFS in the stack direction (frame access).
REQ-014 SHALL have port OFS  input  OW  frame offset.
REQ-015 SHALL have port FCLR  input  1  clear a latched fault.
REQ-016 SHALL have port ADDR  inout  AW  shared address bus.
REQ-017 SHALL have port COUNT  output  AW  entries currently held (|sp-BASE|).
REQ-018 SHALL have ports EMPTY and FULL  output  1 each  sp==BASE and sp==LIMIT respectively.
REQ-019 SHALL have port FCODE  output  2  00 none, 01 overflow, 10 underflow, 11 load out of range.

Function
REQ-020 SHALL implement a two-state FSM, RUN and FAULT.
REQ-021 In RUN, SHALL apply exactly one action per cycle, in priority order: SPL, then SPI and SPD together (no-op), then SPI alone, then SPD alone, then hold.
REQ-022 A push SHALL move sp one step toward LIMIT; a pop SHALL move it one step toward BASE; no wrap-around.
REQ-023 A push while FULL SHALL leave sp unchanged, set FCODE=01 and enter FAULT on the same edge.
REQ-024 A pop while EMPTY SHALL leave sp unchanged, set FCODE=10 and enter FAULT on the same edge.
REQ-025 A load with DIN outside the inclusive range between BASE and LIMIT SHALL leave sp unchanged, set FCODE=11 and enter FAULT; a load inside the range SHALL take effect on the next edge.
REQ-026 In FAULT, SHALL ignore SPI, SPD and SPL; sp and FCODE SHALL hold.
REQ-027 FCLR in FAULT SHALL return to RUN with FCODE=00 on the next edge; any request in that same cycle SHALL be ignored; FCLR in RUN SHALL have no effect.
REQ-028 SHALL drive ADDR combinationally: SPA=0 gives high-Z; SPA=1 and OFSE=0 gives sp; SPA=1 and OFSE=1 gives sp-OFS (GROW_DOWN=0) or sp+OFS (GROW_DOWN=1), modulo 2**AW.
REQ-029 SHALL derive COUNT, EMPTY, FULL and FCODE from registered state only, with no combinational path from the request inputs.
REQ-030 SHALL support both directions of the same LIMIT/BASE ordering: BASE<LIMIT when GROW_DOWN=0, BASE>LIMIT when GROW_DOWN=1; other orderings SHALL be rejected at elaboration.

Reset
REQ-031 AR high at a rising edge SHALL set sp=BASE, state=RUN and FCODE=00, overriding all other inputs, including mid-fault.
REQ-032 After reset, outputs SHALL be COUNT=0, EMPTY=1, FULL=0 and FCODE=00; ADDR SHALL be high-Z unless SPA is high.

Structure
REQ-033 The shared package SHALL hold the FCODE encoding constants and the RUN/FAULT state typedef.
REQ-034 The design SHALL contain one sub-module, stack_addr_drv, for the offset adder and tri-state ADDR driver; the pointer and FSM SHALL stay in stack_ctrl.

Verification
REQ-035 Reset with defaults, then 3 SPI pulses -> COUNT=3 and ADDR=0x03 with SPA=1; add OFSE=1, OFS=2 -> ADDR=0x01.
REQ-036 LIMIT=3, 4 pushes -> FULL=1 after 3; the 4th sets FCODE=01 and sp stays 3; then SPD is ignored; then FCLR -> FCODE=00 and the next SPD gives COUNT=2.
REQ-037 From empty, SPD -> FCODE=10 and sp=BASE; AR asserted during FAULT -> RUN, FCODE=00.
REQ-038 SPI and SPD together at COUNT=2 -> COUNT stays 2 with no fault; SPL with DIN=0x10 together with SPI -> sp=0x10.
REQ-039 GROW_DOWN=1, BASE=0xFF, LIMIT=0xF0: 2 pushes -> sp=0xFD and COUNT=2; SPL with DIN=0x05 -> FCODE=11.
REQ-040 SPA=0 throughout -> ADDR stays high-Z for every sp value; an external driver on ADDR is observed unchanged.
